// File: rtl/rel_addr_agu.sv
// rel_addr_agu: sequential AGU with NIDX index/stride pairs, plain or FFT bit-reversed offsets.
// Define REL_ADDR_AGU_MODULO_EN to add per-index length registers for modulo post-modify.
module rel_addr_agu #(
  parameter int MDATAW = 8,
  parameter int FFTSIZ = 3,
  parameter int NIDX   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    acc,
  input  logic [$clog2(NIDX)-1:0] sel,
  input  logic                    srf,
  input  logic                    inv,
  input  logic                    pst,
  input  logic [MDATAW-1:0]       addr,
  input  logic                    ld_idx,
  input  logic                    ld_stp,
  input  logic                    ld_len,
  input  logic [MDATAW-1:0]       ld_val,
  output logic [MDATAW-1:0]       out,
  output logic                    out_vld
);

  // Mask of the index bits that take part in bit reversal; all ones when FFTSIZ == MDATAW.
  localparam logic [MDATAW-1:0] LOMASK = (MDATAW'(1) << FFTSIZ) - MDATAW'(1);

  function automatic logic [MDATAW-1:0] bitrev_low(input logic [MDATAW-1:0] v);
    logic [MDATAW-1:0] r;
    r = v & ~LOMASK;
    for (int i = 0; i < FFTSIZ; i++) begin
      r[i] = v[FFTSIZ-1-i];
    end
    return r;
  endfunction

  logic [MDATAW-1:0] idx_r [NIDX];
  logic [MDATAW-1:0] stp_r [NIDX];
  logic [MDATAW-1:0] out_r;
  logic              out_vld_r;

  logic [MDATAW-1:0] cur_idx_s;
  logic [MDATAW-1:0] cur_stp_s;
  logic [MDATAW-1:0] offset_s;
  logic [MDATAW-1:0] eff_s;
  logic [MDATAW-1:0] idx_nxt_s;
  logic              pmod_s;

  // Effective address from the pre-update index of the selected pair.
  always_comb begin
    cur_idx_s = idx_r[sel];
    cur_stp_s = stp_r[sel];
    pmod_s    = acc & srf & pst;
    if (inv) begin
      offset_s = bitrev_low(cur_idx_s);
    end else begin
      offset_s = cur_idx_s;
    end
    if (srf) begin
      eff_s = offset_s + addr;
    end else begin
      eff_s = addr;
    end
  end

`ifdef REL_ADDR_AGU_MODULO_EN
  logic [MDATAW-1:0] len_r [NIDX];
  logic [MDATAW-1:0] cur_len_s;
  logic [MDATAW:0]   sum_s;
  logic [MDATAW:0]   diff_s;

  // Post-modify value; sum kept one bit wider so the length compare sees overflow.
  always_comb begin
    cur_len_s = len_r[sel];
    sum_s     = {1'b0, cur_idx_s} + {1'b0, cur_stp_s};
    diff_s    = sum_s - {1'b0, cur_len_s};
    if (inv) begin
      idx_nxt_s = (cur_idx_s & ~LOMASK) | ((cur_idx_s + cur_stp_s) & LOMASK);
    end else if ((cur_len_s != {MDATAW{1'b0}}) && (sum_s >= {1'b0, cur_len_s})) begin
      idx_nxt_s = diff_s[MDATAW-1:0];
    end else begin
      idx_nxt_s = sum_s[MDATAW-1:0];
    end
  end

  // Length registers, loaded only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NIDX; i++) begin
        len_r[i] <= {MDATAW{1'b0}};
      end
    end else if (ld_len) begin
      len_r[sel] <= ld_val;
    end
  end
`else
  logic unused_ld_len_s;
  assign unused_ld_len_s = ld_len;

  // Post-modify value; the inv=1 form keeps the carry of the low field out of the upper bits.
  always_comb begin
    if (inv) begin
      idx_nxt_s = (cur_idx_s & ~LOMASK) | ((cur_idx_s + cur_stp_s) & LOMASK);
    end else begin
      idx_nxt_s = cur_idx_s + cur_stp_s;
    end
  end
`endif

  // Index and stride registers; an explicit load beats a same-cycle post-modify.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NIDX; i++) begin
        idx_r[i] <= {MDATAW{1'b0}};
        stp_r[i] <= MDATAW'(1);
      end
    end else begin
      if (ld_idx) begin
        idx_r[sel] <= ld_val;
      end else if (pmod_s) begin
        idx_r[sel] <= idx_nxt_s;
      end
      if (ld_stp) begin
        stp_r[sel] <= ld_val;
      end
    end
  end

  // Registered address; holds its value between accesses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_r     <= {MDATAW{1'b0}};
      out_vld_r <= 1'b0;
    end else begin
      out_vld_r <= acc;
      if (acc) begin
        out_r <= eff_s;
      end
    end
  end

  assign out     = out_r;
  assign out_vld = out_vld_r;

endmodule

// File: tb/tb_rel_addr_agu.sv
// Scoreboard bench for rel_addr_agu: stimulus pushes expected addresses, a negedge monitor pops them.
module tb_rel_addr_agu;

  logic       clk;
  logic       rst;
  logic       acc;
  logic [1:0] sel;
  logic       srf;
  logic       inv;
  logic       pst;
  logic [7:0] addr;
  logic       ld_idx;
  logic       ld_stp;
  logic       ld_len;
  logic [7:0] ld_val;
  logic [7:0] out;
  logic       out_vld;

  logic [7:0] exp_q [$];
  int         n_cmp;
  int         n_bad;

  rel_addr_agu #(.MDATAW(8), .FFTSIZ(3), .NIDX(4)) dut (
    .clk(clk), .rst(rst), .acc(acc), .sel(sel), .srf(srf), .inv(inv), .pst(pst),
    .addr(addr), .ld_idx(ld_idx), .ld_stp(ld_stp), .ld_len(ld_len), .ld_val(ld_val),
    .out(out), .out_vld(out_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, req);
    end
  endtask

  // Monitor: every valid output must match the oldest queued expectation.
  always @(negedge clk) begin
    if (out_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got 0x%02h, expected no output", out);
      end else begin
        chk("out", out, exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input logic a, input logic [1:0] s, input logic r, input logic i,
                     input logic p, input logic [7:0] ad, input logic li, input logic ls,
                     input logic ll, input logic [7:0] lv, input logic [7:0] ex);
    acc = a; sel = s; srf = r; inv = i; pst = p; addr = ad;
    ld_idx = li; ld_stp = ls; ld_len = ll; ld_val = lv;
    if (a) exp_q.push_back(ex);
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [1:0] s, input logic li, input logic ls, input logic ll,
                    input logic [7:0] v);
    cyc(1'b0, s, 1'b0, 1'b0, 1'b0, 8'h00, li, ls, ll, v, 8'h00);
  endtask

  task automatic ac(input logic [1:0] s, input logic r, input logic i, input logic p,
                    input logic [7:0] ad, input logic [7:0] ex);
    cyc(1'b1, s, r, i, p, ad, 1'b0, 1'b0, 1'b0, 8'h00, ex);
  endtask

  task automatic idle();
    cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Read an index back through the datapath: srf=1, pst=0, addr=0 returns idx unchanged.
  task automatic rd_idx(input logic [1:0] s, input logic [7:0] ex);
    ac(s, 1'b1, 1'b0, 1'b0, 8'h00, ex);
  endtask

  logic [7:0] brv [8];
  logic [7:0] mod_exp [5];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    acc = 1'b0; sel = 2'd0; srf = 1'b0; inv = 1'b0; pst = 1'b0; addr = 8'h00;
    ld_idx = 1'b0; ld_stp = 1'b0; ld_len = 1'b0; ld_val = 8'h00;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("reset_out", out, 8'h00);
    chk("reset_vld", {7'd0, out_vld}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Bit-reverse sweep.
    brv = '{8'h30, 8'h34, 8'h32, 8'h36, 8'h31, 8'h35, 8'h33, 8'h37};
    ld(2'd0, 1'b1, 1'b1, 1'b0, 8'h10);
    ld(2'd0, 1'b0, 1'b1, 1'b0, 8'h01);
    for (int k = 0; k < 8; k++) ac(2'd0, 1'b1, 1'b1, 1'b1, 8'h20, brv[k]);
    rd_idx(2'd0, 8'h10);

    // Linear wrap past 0xFF.
    ld(2'd1, 1'b1, 1'b0, 1'b0, 8'hFE);
    ac(2'd1, 1'b1, 1'b0, 1'b1, 8'h00, 8'hFE);
    ac(2'd1, 1'b1, 1'b0, 1'b1, 8'h00, 8'hFF);
    ac(2'd1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
    rd_idx(2'd1, 8'h01);

    // Stride loaded alongside a post-modify: old stride used this cycle, new from next.
    cyc(1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h10, 8'h01);
    ac(2'd1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h02);
    rd_idx(2'd1, 8'h12);

    // Absolute / no-modify, with idx and stp loaded in the same cycle.
    ld(2'd2, 1'b1, 1'b1, 1'b0, 8'h40);
    ac(2'd2, 1'b0, 1'b0, 1'b1, 8'h7A, 8'h7A);
    ac(2'd2, 1'b1, 1'b0, 1'b0, 8'h7A, 8'hBA);
    ac(2'd2, 1'b1, 1'b0, 1'b1, 8'h00, 8'h40);
    rd_idx(2'd2, 8'h80);
    idle();

    // Load beats post-modify on the same index.
    ld(2'd0, 1'b1, 1'b0, 1'b0, 8'h05);
    ld(2'd0, 1'b0, 1'b1, 1'b0, 8'h02);
    cyc(1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 8'h80, 8'h15);
    rd_idx(2'd0, 8'h80);

    // Modulo addressing (plain wrap without the feature).
`ifdef REL_ADDR_AGU_MODULO_EN
    mod_exp = '{8'd3, 8'd0, 8'd2, 8'd4, 8'd1};
`else
    mod_exp = '{8'd3, 8'd5, 8'd7, 8'd9, 8'd11};
`endif
    ld(2'd3, 1'b0, 1'b0, 1'b1, 8'd5);
    ld(2'd3, 1'b0, 1'b1, 1'b0, 8'd2);
    ld(2'd3, 1'b1, 1'b0, 1'b0, 8'd3);
    for (int k = 0; k < 5; k++) ac(2'd3, 1'b1, 1'b0, 1'b1, 8'h00, mod_exp[k]);

    // Asynchronous reset while out_vld is high.
    ac(2'd0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'hA5);
    acc = 1'b0;
    #6;
    chk("pre_reset_vld", {7'd0, out_vld}, 8'h01);
    rst = 1'b0;
    #1;
    chk("midrst_out", out, 8'h00);
    chk("midrst_vld", {7'd0, out_vld}, 8'h00);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    ac(2'd0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
    ac(2'd0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h01);
    idle();
    idle();
    chk("queue_drained", 8'(exp_q.size()), 8'h00);
    chk("hold_vld_low", {7'd0, out_vld}, 8'h00);
    chk("hold_out", out, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
